// File: rtl/pixel_stream_tx_pkg.sv
// Purpose: shared types and constants for the pixel streamer and its UART serialiser.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional macro SNN_TX_PARITY_EN widens the frame to 11 bits.
package snn_uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP,
        GAP,
        FIN
    } tx_state_t;

    // Start + data + optional parity + stop.
    function automatic int bits_per_frame();
`ifdef SNN_TX_PARITY_EN
        return 11;
`else
        return 10;
`endif
    endfunction

endpackage

// File: rtl/pixel_stream_tx_if.sv
// Purpose: groups the streamer's control, memory and serial signals into one bundle.
// Latency: n/a (wiring only).
// Backpressure: none; the memory is assumed to answer every read one cycle later.
// Ports: start/abort (requests), mem_addr/mem_rdata (sync memory), tx/busy/done/byte_idx (status).
interface pixel_stream_tx_if #(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 7
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              tx;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  byte_idx;

    // slave: the streamer itself; master: whoever drives requests and models the memory.
    modport slave  (input  start, abort, mem_rdata,
                    output mem_addr, tx, busy, done, byte_idx);
    modport master (output start, abort, mem_rdata,
                    input  mem_addr, tx, busy, done, byte_idx);
endinterface

// File: rtl/pixel_stream_tx_uart_tx_core.sv
// Purpose: serialises one byte as a UART frame (start, 8 data LSB first, [parity], stop).
// Latency: tx drops to the start bit on the edge after load_i; frame_done_o in the last stop cycle.
// Backpressure: none; load_i must only be pulsed while idle. abort_i forces tx high at once.
// Ports: clk/rst_n, load_i + data_in_i (byte to send), abort_i, tx_o, bit_end_o, bit_cnt_o, frame_done_o.
module uart_tx_core
    import snn_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic                      abort_i,
    input  logic [UART_DATA_BITS-1:0] data_in_i,
    output logic                      tx_o,
    output logic                      bit_end_o,
    output logic [3:0]                bit_cnt_o,
    output logic                      frame_done_o
);

    localparam int          FRAME_BITS = bits_per_frame();
    // The start bit goes straight to tx on load, so the shifter holds the remaining bits.
    localparam int          SHR_W      = FRAME_BITS - 1;
    localparam logic [15:0] TIMER_LOAD = 16'(CLKS_PER_BIT - 1);

    logic [15:0]      timer_q, timer_d;
    logic [SHR_W-1:0] shreg_q, shreg_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             active_q, active_d;
    logic             tx_q, tx_d;

    logic bit_end;
    logic last_bit;

    assign bit_end  = active_q && (timer_q == '0);
    assign last_bit = (bit_cnt_q == 4'(FRAME_BITS - 1));

    always_comb begin
        timer_d   = timer_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        active_d  = active_q;
        tx_d      = tx_q;
        if (abort_i) begin
            active_d  = 1'b0;
            tx_d      = UART_IDLE;
            timer_d   = '0;
            bit_cnt_d = '0;
        end else if (load_i) begin
            active_d  = 1'b1;
            tx_d      = 1'b0;
            timer_d   = TIMER_LOAD;
            bit_cnt_d = '0;
`ifdef SNN_TX_PARITY_EN
            shreg_d   = {UART_IDLE, ^data_in_i, data_in_i};
`else
            shreg_d   = {UART_IDLE, data_in_i};
`endif
        end else if (bit_end) begin
            if (last_bit) begin
                active_d = 1'b0;
                tx_d     = UART_IDLE;
            end else begin
                // Shift in idle-level ones so the stop bit falls out last.
                tx_d      = shreg_q[0];
                shreg_d   = {UART_IDLE, shreg_q[SHR_W-1:1]};
                timer_d   = TIMER_LOAD;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (active_q) begin
            timer_d = timer_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            active_q  <= 1'b0;
            tx_q      <= UART_IDLE;
        end else begin
            timer_q   <= timer_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            active_q  <= active_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_o         = tx_q;
    assign bit_end_o    = bit_end;
    assign bit_cnt_o    = bit_cnt_q;
    assign frame_done_o = bit_end && last_bit;

endmodule

// File: rtl/pixel_stream_tx.sv
// Purpose: streams NUM_BYTES bytes from a synchronous memory out as back-to-back UART frames.
// Latency: 2 + (frame_bits+GAP_BITS)*CLKS_PER_BIT cycles per byte (no gap after the last); done one cycle later.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next edge.
// Ports: clk, rst_n, bus (pixel_stream_tx_if.slave: start, abort, mem_addr, mem_rdata, tx, busy, done, byte_idx).
// Optional macro SNN_TX_PARITY_EN adds an even-parity bit before the stop bit.
module pixel_stream_tx
    import snn_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2604,
    parameter int NUM_BYTES    = 98,
    parameter int ADDR_W       = 10,
    parameter int BASE_ADDR    = 0,
    parameter int GAP_BITS     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    pixel_stream_tx_if.slave bus
);

    localparam int                IDX_W      = $clog2(NUM_BYTES + 1);
    localparam int                FRAME_BITS = bits_per_frame();
    localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_BYTES - 1);
    localparam logic [31:0]       GAP_LOAD   = (GAP_BITS > 0) ? 32'(GAP_BITS * CLKS_PER_BIT - 1) : 32'd0;

    tx_state_t        state_q, state_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [31:0]      gap_cnt_q, gap_cnt_d;

    logic       core_load;
    logic       core_abort;
    logic       core_bit_end;
    logic [3:0] core_bit_cnt;
    logic       core_frame_done;
    logic       core_tx;

    // abort only matters once a transfer is under way; in IDLE it merely vetoes start.
    assign core_abort = bus.abort && (state_q != IDLE);
    assign core_load  = (state_q == LOAD);

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        if (core_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d    = FETCH;
                        byte_idx_d = '0;
                    end
                end
                FETCH: state_d = LOAD;
                LOAD:  state_d = START;
                START: begin
                    if (core_bit_end) state_d = DATA;
                end
                DATA: begin
                    // DATA covers the parity bit too; leave when the bit before stop ends.
                    if (core_bit_end && (core_bit_cnt == 4'(FRAME_BITS - 2))) state_d = STOP;
                end
                STOP: begin
                    if (core_frame_done) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        if (byte_idx_q == LAST_IDX) begin
                            state_d = FIN;
                        end else if (GAP_BITS > 0) begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_LOAD;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) state_d = FETCH;
                    else                 gap_cnt_d = gap_cnt_q - 32'd1;
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (core_load),
        .abort_i      (core_abort),
        .data_in_i    (bus.mem_rdata),
        .tx_o         (core_tx),
        .bit_end_o    (core_bit_end),
        .bit_cnt_o    (core_bit_cnt),
        .frame_done_o (core_frame_done)
    );

    // byte_idx counts completed bytes, so it is also the index of the byte being fetched.
    assign bus.mem_addr = BASE_A + ADDR_W'(byte_idx_q);
    assign bus.tx       = core_tx;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == FIN);
    assign bus.byte_idx = byte_idx_q;

endmodule
